// File: rtl/i2s_tdm_tx_if.sv
// Sample-source handshake for i2s_tdm_tx.
// One transfer = one full frame of CHANNELS samples, taken when valid & ready.
//   valid : source has a frame on audio
//   ready : serializer holding buffer is empty
//   audio : channel c at [c*DATA_BIT +: DATA_BIT], channel 0 = left
interface i2s_tdm_tx_if #(
    parameter int CHANNELS = 2,
    parameter int DATA_BIT = 16
);
    logic                         valid;
    logic                         ready;
    logic [CHANNELS*DATA_BIT-1:0] audio;

    modport master (output valid, output audio, input  ready);
    modport slave  (input  valid, input  audio, output ready);
endinterface

// File: rtl/i2s_tdm_tx.sv
// I2S / TDM serializer with a one-frame holding buffer.
// Serializes CHANNELS slots of SLOT_BIT SCLK periods each, in I2S,
// left-justified or right-justified format. A frame is loaded at every
// frame boundary; if the holding buffer is empty, silence is sent and
// o_underrun pulses.
// Ports:
//   i_clk_12_288  system clock, everything on its rising edge
//   i_reset       asynchronous active-high reset
//   i_sclk        one-cycle tick per SCLK period
//   i_enable      run request, sampled at frame boundaries while running
//   i_mode        0=I2S 1=LJ 2=RJ 3=I2S, latched at frame load
//   aud           frame handshake (valid/ready/audio)
//   o_sd, o_ws    registered serial data / word select
//   o_frame_start one-cycle pulse per frame load
//   o_underrun    one-cycle pulse when a frame loads from an empty buffer
module i2s_tdm_tx #(
    parameter int DATA_BIT = 16,
    parameter int SLOT_BIT = 32,
    parameter int CHANNELS = 2
) (
    input  logic               i_clk_12_288,
    input  logic               i_reset,
    input  logic               i_sclk,
    input  logic               i_enable,
    input  logic [1:0]         i_mode,
    i2s_tdm_tx_if.slave        aud,
    output logic               o_sd,
    output logic               o_ws,
    output logic               o_frame_start,
    output logic               o_underrun
);
    localparam int FRAME_BITS = CHANNELS * SLOT_BIT;
    localparam int W          = CHANNELS * DATA_BIT;
    localparam int CW         = $clog2(FRAME_BITS);
    localparam int IW         = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] HALF = CW'(FRAME_BITS / 2);

    localparam logic [1:0] MODE_I2S = 2'd0;
    localparam logic [1:0] MODE_LJ  = 2'd1;
    localparam logic [1:0] MODE_RJ  = 2'd2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [W-1:0]  frame_q, frame_d;
    logic [1:0]    mode_q, mode_d;
    logic          lj_prev_q, lj_prev_d;
    logic          sd_q, sd_d;
    logic          ws_q, ws_d;
    logic          fs_q, fs_d;
    logic          und_q, und_d;

    // Left-justified bit for frame position b: sample MSB first, zero pad after.
    function automatic logic lj_bit(input logic [W-1:0] fr, input logic [CW-1:0] b);
        int s;
        int p;
        s = int'(b) / SLOT_BIT;
        p = int'(b) % SLOT_BIT;
        if (p < DATA_BIT) return fr[IW'(s*DATA_BIT + DATA_BIT - 1 - p)];
        return 1'b0;
    endfunction

    // Right-justified bit: zero pad first, sample LSB lands on the slot's last bit.
    function automatic logic rj_bit(input logic [W-1:0] fr, input logic [CW-1:0] b);
        int s;
        int p;
        s = int'(b) / SLOT_BIT;
        p = int'(b) % SLOT_BIT;
        if (p >= SLOT_BIT - DATA_BIT) return fr[IW'(s*DATA_BIT + SLOT_BIT - 1 - p)];
        return 1'b0;
    endfunction

    always_comb begin
        logic hs;
        logic load;
        logic emit;
        logic lj;

        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        frame_d     = frame_q;
        mode_d      = mode_q;
        lj_prev_d   = lj_prev_q;
        sd_d        = sd_q;
        ws_d        = ws_q;
        fs_d        = 1'b0;
        und_d       = 1'b0;
        load        = 1'b0;
        emit        = 1'b0;
        lj          = 1'b0;
        hs          = aud.valid & ~hold_full_q;

        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                sd_d      = 1'b0;
                ws_d      = 1'b0;
                lj_prev_d = 1'b0;
                if (i_enable) begin
                    state_d = RUN;
                    // Armed on the last position so the first tick loads a frame.
                    cnt_d   = LAST;
                end
            end
            RUN: begin
                if (i_sclk) begin
                    if (cnt_q == LAST) begin
                        if (!i_enable) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            sd_d      = 1'b0;
                            ws_d      = 1'b0;
                            lj_prev_d = 1'b0;
                        end else begin
                            load    = 1'b1;
                            mode_d  = (i_mode == 2'd3) ? MODE_I2S : i_mode;
                            frame_d = hold_full_q ? hold_q : '0;
                            und_d   = ~hold_full_q;
                            fs_d    = 1'b1;
                            cnt_d   = '0;
                            emit    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        emit  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            lj = lj_bit(frame_d, cnt_d);
            // lj_prev carries the LJ bit one SCLK late; that delay is I2S,
            // including the previous frame's last bit at position 0.
            unique case (mode_d)
                MODE_LJ: sd_d = lj;
                MODE_RJ: sd_d = rj_bit(frame_d, cnt_d);
                default: sd_d = lj_prev_q;
            endcase
            lj_prev_d = lj;
            ws_d      = (cnt_d >= HALF) ^ (mode_d != MODE_I2S);
        end

        // A load consumes the old contents; a same-cycle handshake refills for the next frame.
        hold_full_d = (hold_full_q & ~load) | hs;
        if (hs) hold_d = aud.audio;
    end

    always_ff @(posedge i_clk_12_288 or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            frame_q     <= '0;
            mode_q      <= MODE_I2S;
            lj_prev_q   <= 1'b0;
            sd_q        <= 1'b0;
            ws_q        <= 1'b0;
            fs_q        <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            frame_q     <= frame_d;
            mode_q      <= mode_d;
            lj_prev_q   <= lj_prev_d;
            sd_q        <= sd_d;
            ws_q        <= ws_d;
            fs_q        <= fs_d;
            und_q       <= und_d;
        end
    end

    assign aud.ready     = ~hold_full_q;
    assign o_sd          = sd_q;
    assign o_ws          = ws_q;
    assign o_frame_start = fs_q;
    assign o_underrun    = und_q;
endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: two instances (2ch x 32-bit slots, 4ch x 16-bit
// slots, both 64-bit frames) share clock, SCLK, enable and mode. A
// frame-level model predicts every output each cycle; literal frames pin
// the model for the directed cases.
module tb_i2s_tdm_tx;
    localparam int FB = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic en = 1'b0;
    logic [1:0] mode = 2'd0;
    bit rnd_tick = 1'b0;
    logic [1:0] sd, ws, fs, und;

    always #5 clk = ~clk;

    i2s_tdm_tx_if #(.CHANNELS(2), .DATA_BIT(16)) a0 ();
    i2s_tdm_tx_if #(.CHANNELS(4), .DATA_BIT(16)) a1 ();

    i2s_tdm_tx #(.DATA_BIT(16), .SLOT_BIT(32), .CHANNELS(2)) u0 (
        .i_clk_12_288(clk), .i_reset(rst), .i_sclk(sclk), .i_enable(en),
        .i_mode(mode), .aud(a0.slave), .o_sd(sd[0]), .o_ws(ws[0]),
        .o_frame_start(fs[0]), .o_underrun(und[0]));

    i2s_tdm_tx #(.DATA_BIT(16), .SLOT_BIT(16), .CHANNELS(4)) u1 (
        .i_clk_12_288(clk), .i_reset(rst), .i_sclk(sclk), .i_enable(en),
        .i_mode(mode), .aud(a1.slave), .o_sd(sd[1]), .o_ws(ws[1]),
        .o_frame_start(fs[1]), .o_underrun(und[1]));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int SL[2]  = '{32, 16};
    int CHN[2] = '{2, 4};
    logic [15:0] fr[2][4];
    logic [15:0] hd[2][4];
    bit hf[2], run[2], first[2], carry[2], emitted[2];
    int b[2], md[2];
    bit e_sd[2], e_ws[2], e_fs[2], e_und[2];

    function automatic bit vld(int k);
        return (k == 0) ? a0.valid : a1.valid;
    endfunction
    function automatic bit rdy(int k);
        return (k == 0) ? a0.ready : a1.ready;
    endfunction
    function automatic logic [15:0] smp(int k, int c);
        logic [63:0] v;
        v = (k == 0) ? {32'h0, a0.audio} : a1.audio;
        return v[c*16 +: 16];
    endfunction
    function automatic bit lj(int k, int pos);
        int s, p;
        s = pos / SL[k];
        p = pos % SL[k];
        return (p < 16) ? fr[k][s][15-p] : 1'b0;
    endfunction
    function automatic bit rj(int k, int pos);
        int s, p;
        s = pos / SL[k];
        p = pos % SL[k];
        return (p >= SL[k] - 16) ? fr[k][s][SL[k]-1-p] : 1'b0;
    endfunction

    task automatic emit(int k);
        emitted[k] = 1'b1;
        case (md[k])
            1: e_sd[k] = lj(k, b[k]);
            2: e_sd[k] = rj(k, b[k]);
            default: e_sd[k] = (b[k] == 0) ? carry[k] : lj(k, b[k] - 1);
        endcase
        e_ws[k] = (b[k] >= FB/2) != (md[k] != 0);
    endtask

    task automatic step(int k);
        bit hs;
        hs = vld(k) && !hf[k];
        e_fs[k] = 1'b0;
        e_und[k] = 1'b0;
        emitted[k] = 1'b0;
        if (!run[k]) begin
            if (en) begin run[k] = 1'b1; b[k] = FB - 1; first[k] = 1'b1; end
        end else if (sclk) begin
            if (b[k] == FB - 1) begin
                if (!en) begin
                    run[k] = 1'b0; b[k] = 0; e_sd[k] = 1'b0; e_ws[k] = 1'b0;
                end else begin
                    carry[k] = first[k] ? 1'b0 : lj(k, FB - 1);
                    first[k] = 1'b0;
                    md[k] = (mode == 2'd3) ? 0 : int'(mode);
                    for (int c = 0; c < 4; c++) fr[k][c] = hf[k] ? hd[k][c] : 16'h0;
                    e_und[k] = !hf[k];
                    hf[k] = 1'b0;
                    e_fs[k] = 1'b1;
                    b[k] = 0;
                    emit(k);
                end
            end else begin
                b[k]++;
                emit(k);
            end
        end
        if (hs) begin
            for (int c = 0; c < CHN[k]; c++) hd[k][c] = smp(k, c);
            hf[k] = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                hf[k] = 0; run[k] = 0; first[k] = 1; carry[k] = 0; emitted[k] = 0;
                b[k] = 0; md[k] = 0; e_sd[k] = 0; e_ws[k] = 0; e_fs[k] = 0; e_und[k] = 0;
                for (int c = 0; c < 4; c++) begin fr[k][c] = 16'h0; hd[k][c] = 16'h0; end
            end
        end else begin
            step(0);
            step(1);
        end
    end

    // ---------------- per-cycle compare + frame capture ----------------
    logic [63:0] cap_sd[2], cap_ws[2], last_sd[2], last_ws[2];

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("sd%0d", k), 64'(sd[k]), 64'(e_sd[k]));
                chk($sformatf("ws%0d", k), 64'(ws[k]), 64'(e_ws[k]));
                chk($sformatf("fs%0d", k), 64'(fs[k]), 64'(e_fs[k]));
                chk($sformatf("und%0d", k), 64'(und[k]), 64'(e_und[k]));
                chk($sformatf("ready%0d", k), 64'(rdy(k)), 64'(!hf[k]));
                if (emitted[k]) begin
                    cap_sd[k][63 - b[k]] = sd[k];
                    cap_ws[k][63 - b[k]] = ws[k];
                    if (b[k] == FB - 1) begin
                        last_sd[k] = cap_sd[k];
                        last_ws[k] = cap_ws[k];
                    end
                end
            end
        end
    end

    // SCLK tick: every 4th clock in directed phases, random in the soak phase.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            cnt++;
            sclk = rnd_tick ? ($urandom_range(0, 2) == 0) : (cnt % 4 == 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(int k, input logic [63:0] data);
        int i;
        if (k == 0) begin a0.audio = data[31:0]; a0.valid = 1'b1; end
        else        begin a1.audio = data;       a1.valid = 1'b1; end
        for (i = 0; i < 2000; i++) begin
            if (rdy(k)) break;
            @(negedge clk); #1;
        end
        if (i == 2000) chk("push_timeout", 64'(rdy(k)), 64'd1);
        @(negedge clk); #1;
        if (k == 0) a0.valid = 1'b0; else a1.valid = 1'b0;
    endtask

    task automatic wait_fs();
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fs[0]) break;
        end
        if (i == 2000) chk("fs_timeout", 64'(fs[0]), 64'd1);
    endtask

    task automatic wait_pos(int pos);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (run[0] && b[0] == pos && emitted[0]) break;
        end
        if (i == 2000) chk("pos_timeout", 64'(b[0]), 64'(pos));
    endtask

    localparam logic [63:0] I2S0   = {1'b0, 16'hA5F0, 15'h0, 1'b0, 16'h0F0F, 15'h0};
    localparam logic [63:0] LJ0    = {16'hA5F0, 16'h0, 16'h0F0F, 16'h0};
    localparam logic [63:0] RJ0    = {16'h0, 16'hA5F0, 16'h0, 16'h0F0F};
    localparam logic [63:0] I2S1   = {1'b0, 48'h1111_2222_3333, 15'h2222};
    localparam logic [63:0] WS_I2S = {32'h0, 32'hFFFF_FFFF};
    localparam logic [63:0] WS_J   = {32'hFFFF_FFFF, 32'h0};
    localparam logic [63:0] D0     = 64'h0000_0000_0F0F_A5F0;
    localparam logic [63:0] D1     = 64'h4444_3333_2222_1111;

    initial begin
        a0.valid = 1'b0; a0.audio = '0;
        a1.valid = 1'b0; a1.audio = '0;
        repeat (3) @(negedge clk);
        chk("rst_sd", 64'(sd), 64'd0);
        chk("rst_ws", 64'(ws), 64'd0);
        chk("rst_pulses", 64'({fs, und}), 64'd0);
        chk("rst_ready", 64'({a1.ready, a0.ready}), 64'd3);
        #1 rst = 1'b0;

        // I2S frame, then LJ, then RJ, then an underrun frame.
        mode = 2'd0;
        push(0, D0);
        push(1, D1);
        en = 1'b1;
        wait_fs();
        chk("f1_und", 64'(und), 64'd0);
        chk("f1_fs1", 64'(fs[1]), 64'd1);
        #1 mode = 2'd1;
        push(0, D0);
        push(1, {$urandom, $urandom});
        wait_fs();
        chk("i2s_sd0", last_sd[0], I2S0);
        chk("i2s_ws0", last_ws[0], WS_I2S);
        chk("i2s_sd1", last_sd[1], I2S1);
        chk("i2s_ws1", last_ws[1], WS_I2S);
        #1 mode = 2'd2;
        push(0, D0);
        wait_fs();
        chk("lj_sd0", last_sd[0], LJ0);
        chk("lj_ws0", last_ws[0], WS_J);
        wait_fs();
        chk("underrun_pulse", 64'(und), 64'd3);
        chk("underrun_fs", 64'(fs), 64'd3);
        chk("rj_sd0", last_sd[0], RJ0);
        wait_fs();
        chk("silence_sd0", last_sd[0], 64'h0);

        // Enable dropped mid-frame: frame completes, then idle.
        #1 mode = 2'd0;
        push(0, D0);
        wait_fs();
        wait_pos(10);
        #1 en = 1'b0;
        repeat (300) @(negedge clk);
        chk("idle_model", 64'(run[0]), 64'd0);
        chk("idle_sd", 64'(sd), 64'd0);
        chk("idle_ws", 64'(ws), 64'd0);
        chk("idle_sd_frame", last_sd[0], I2S0);

        // Reset mid-frame with a full holding buffer.
        #1 en = 1'b1;
        push(0, D0);
        wait_fs();
        push(0, D0);
        wait_pos(40);
        chk("pre_rst_ws", 64'(ws[0]), 64'd1);
        chk("pre_rst_ready", 64'(a0.ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out", 64'({sd[0], ws[0], fs[0], und[0]}), 64'd0);
        chk("mid_rst_ready", 64'(a0.ready), 64'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Soak: random data, valid, ticks, mode and enable.
        rnd_tick = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk); #1;
            a0.valid = $urandom_range(0, 3) == 0;
            a0.audio = $urandom;
            a1.valid = $urandom_range(0, 3) == 0;
            a1.audio = {$urandom, $urandom};
            if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 799) == 0) en = ~en;
            if (i == 3000) a0.valid = 1'b1;
            if (i == 5000) rst = 1'b1;
            if (i == 5002) begin rst = 1'b0; en = 1'b1; end
        end
        rnd_tick = 1'b0;
        a0.valid = 1'b0;
        a1.valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
